cache_line_store: RTL and testbench
===================================

// Module: cache_line_store
// PURPOSE
//  Parametrised data array for the L1 cache: NUM_LINES lines of WORDS_PER_LINE words.
//  Serves CPU word reads (registered) and byte-enabled writes.
//  Refills a line one beat at a time over a valid/ready stream from memory.
//  Streams a victim line out (evict) over a valid/ready stream for write-back.
//  Sits between the cache controller FSM and the memory interface.
// PARAMETERS
//  DATA_W          32  word width in bits; must be a multiple of 8
//  WORDS_PER_LINE  4   words per line; power of 2, >= 2
//  NUM_LINES       32  number of lines; power of 2, >= 2
//  OFFSET_W        $clog2(WORDS_PER_LINE)  word-offset width (derived)
//  INDEX_W         $clog2(NUM_LINES)       line-index width (derived)
// PORTS
//  clk           in   1         clock
//  reset         in   1         reset, asynchronous, active-high
//  cpu_rd        in   1         word read request
//  cpu_wr        in   1         word write request
//  cpu_index     in   INDEX_W   line index for the CPU access
//  cpu_offset    in   OFFSET_W  word offset within the line
//  cpu_be        in   DATA_W/8  byte enables for cpu_wr
//  cpu_wdata     in   DATA_W    write data
//  cpu_rdata     out  DATA_W    read data, registered
//  cpu_rvalid    out  1         1-cycle pulse; cpu_rdata is valid
//  busy          out  1         high in REFILL or EVICT; CPU requests are ignored
//  refill_start  in   1         begin a line refill at refill_index
//  refill_index  in   INDEX_W   line to refill
//  refill_valid  in   1         beat present on refill_data
//  refill_data   in   DATA_W    refill beat; beat k goes to word k
//  refill_ready  out  1         array accepts a beat
//  refill_done   out  1         1-cycle pulse after the last beat is written
//  evict_start   in   1         begin streaming line evict_index out
//  evict_index   in   INDEX_W   line to evict
//  evict_valid   out  1         evict_data is valid
//  evict_data    out  DATA_W    victim word; beat k = word k
//  evict_last    out  1         current beat is word WORDS_PER_LINE-1
//  evict_ready   in   1         consumer accepts the beat
// BEHAVIOUR
//  Reset:
//   - Async. State -> IDLE; beat counter = 0; whole array cleared to 0.
//   - All outputs 0: cpu_rdata, cpu_rvalid, busy, refill_ready, refill_done,
//     evict_valid, evict_data, evict_last.
//   - Reset mid-refill or mid-evict abandons the transfer. No refill_done is produced.
//  FSM states: IDLE, REFILL, EVICT.
//   - IDLE priority: evict_start > refill_start > CPU op.
//   - A start pulse latches its index, clears the beat counter and enters its state.
//   - A CPU op issued in the same cycle as a start is dropped; the controller must not issue both.
//   - Start pulses while busy are ignored.
//  CPU read (IDLE only):
//   - cpu_rd at edge N -> cpu_rdata = word, cpu_rvalid=1 during cycle N+1.
//   - cpu_rdata holds its value until the next accepted read.
//  CPU write (IDLE only):
//   - Bytes with cpu_be[b]=1 are written at the edge; the other bytes are kept.
//   - cpu_be=0 leaves the word unchanged.
//   - cpu_rd and cpu_wr to the same word in the same cycle: the write is performed
//     and the read returns the OLD word (read-before-write).
//  REFILL:
//   - refill_ready=1 throughout.
//   - Each edge with refill_valid=1 writes refill_data to word[beat] and increments beat.
//   - When the last beat (WORDS_PER_LINE-1) is accepted: state -> IDLE, and
//     refill_done=1 for the next cycle only.
//   - The last beat is readable by the CPU from the cycle after refill_done rises.
//  EVICT:
//   - evict_valid=1 throughout; evict_data = word[beat] of the latched line.
//   - evict_last = (beat == WORDS_PER_LINE-1).
//   - evict_data and evict_last hold stable while evict_valid=1 and evict_ready=0.
//   - Each edge with evict_ready=1 increments beat.
//   - When the last beat is accepted: state -> IDLE; evict_valid=0 from the next cycle.
//  Beat counter: OFFSET_W bits; wraps to 0 after the last beat. No other width extension.
//  busy = (state != IDLE), driven from registered state.
// TESTING
//  1. Reset, then cpu_rd idx 5 off 2 -> cpu_rvalid pulse, cpu_rdata=0.
//  2. cpu_wr idx 3 off 1 wdata=0xAABBCCDD be=4'b1111, then wdata=0x11223344 be=4'b0101
//     -> read returns 0xAA22CC44.
//  3. refill_start idx 7; beats 0x10,0x20,0x30,0x40, with refill_valid low for 2 cycles
//     between beats 1 and 2 -> refill_done 1 cycle after 0x40; reads of off 0..3 return
//     those values; CPU write during busy has no effect.
//  4. Evict idx 7 with evict_ready toggled 1,0,0,1,1,1 -> beats 0x10..0x40 in order,
//     data stable while stalled, evict_last only on 0x40.
//  5. evict_start and refill_start in the same cycle -> EVICT taken, refill ignored;
//     reset asserted mid-evict (beat 2) -> all outputs 0, busy=0, array reads 0.
//  6. Non-default parameters DATA_W=64, WORDS_PER_LINE=8, NUM_LINES=64: refill and evict
//     of line 63 -> 8 beats each; counter wrap returns cleanly to IDLE.

Source files
------------

// File: rtl/cache_line_store.sv
// cache_line_store
// ----------------
// L1 cache data array: NUM_LINES lines of WORDS_PER_LINE words of DATA_W bits.
// Three users share the array, one at a time, under a small IDLE/REFILL/EVICT
// state machine:
//   - CPU word reads (registered, one-cycle rvalid pulse) and byte-enabled
//     writes. These are served only in IDLE.
//   - Line refill from memory: one beat per accepted valid/ready handshake,
//     beat k lands in word k.
//   - Victim eviction: the latched line is streamed out over valid/ready,
//     beat k = word k, with evict_last flagging the final word.
// The array is held in flip-flops rather than block RAM because an
// asynchronous reset must clear every word.
//
// Ports
//   clk, reset                    clock; asynchronous active-high reset
//   cpu_rd / cpu_wr               CPU word read / write request (IDLE only)
//   cpu_index, cpu_offset         line index and word offset of the CPU access
//   cpu_be, cpu_wdata             byte enables and write data
//   cpu_rdata, cpu_rvalid         registered read data and its 1-cycle strobe
//   busy                          high while refilling or evicting
//   refill_start, refill_index    begin a refill of the given line
//   refill_valid, refill_data     refill beat stream in
//   refill_ready, refill_done     beat accept; 1-cycle pulse after the last beat
//   evict_start, evict_index      begin streaming the given line out
//   evict_valid, evict_data,
//   evict_last, evict_ready       victim beat stream out
module cache_line_store #(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES      = 32,
    localparam int OFFSET_W      = $clog2(WORDS_PER_LINE),
    localparam int INDEX_W       = $clog2(NUM_LINES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_rd,
    input  logic                cpu_wr,
    input  logic [INDEX_W-1:0]  cpu_index,
    input  logic [OFFSET_W-1:0] cpu_offset,
    input  logic [DATA_W/8-1:0] cpu_be,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_rvalid,
    output logic                busy,
    input  logic                refill_start,
    input  logic [INDEX_W-1:0]  refill_index,
    input  logic                refill_valid,
    input  logic [DATA_W-1:0]   refill_data,
    output logic                refill_ready,
    output logic                refill_done,
    input  logic                evict_start,
    input  logic [INDEX_W-1:0]  evict_index,
    output logic                evict_valid,
    output logic [DATA_W-1:0]   evict_data,
    output logic                evict_last,
    input  logic                evict_ready
);

    localparam int NBYTES = DATA_W / 8;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS_PER_LINE - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_EVICT  = 2'd2;

    logic [DATA_W-1:0]   r_mem [NUM_LINES][WORDS_PER_LINE];
    logic [1:0]          r_state;
    logic [OFFSET_W-1:0] r_beat;
    logic [INDEX_W-1:0]  r_index;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                r_refill_done;

    logic [DATA_W-1:0]   w_be_mask;
    logic [DATA_W-1:0]   w_cpu_word;
    logic [DATA_W-1:0]   w_cpu_merged;
    logic                w_idle_free;
    logic                w_cpu_wr_acc;
    logic                w_refill_wr;

    // Expand byte enables into a bit mask for the read-modify-write merge.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_be_mask
            assign w_be_mask[gi*8 +: 8] = {8{cpu_be[gi]}};
        end
    endgenerate

    // A CPU op is dropped whenever any start pulse arrives in the same cycle.
    assign w_idle_free  = (r_state == S_IDLE) && !evict_start && !refill_start;
    assign w_cpu_wr_acc = w_idle_free && cpu_wr;
    assign w_refill_wr  = (r_state == S_REFILL) && refill_valid;

    assign w_cpu_word   = r_mem[cpu_index][cpu_offset];
    assign w_cpu_merged = (w_cpu_word & ~w_be_mask) | (cpu_wdata & w_be_mask);

    // Data array. A read in the same cycle as a write to the same word sees
    // the pre-write value because both are sampled at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < NUM_LINES; l++) begin
                for (int w = 0; w < WORDS_PER_LINE; w++) begin
                    r_mem[l][w] <= '0;
                end
            end
        end else if (w_refill_wr) begin
            r_mem[r_index][r_beat] <= refill_data;
        end else if (w_cpu_wr_acc) begin
            r_mem[cpu_index][cpu_offset] <= w_cpu_merged;
        end
    end

    // Control: state, beat counter, latched line index and CPU read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_beat        <= '0;
            r_index       <= '0;
            r_rdata       <= '0;
            r_rvalid      <= 1'b0;
            r_refill_done <= 1'b0;
        end else begin
            r_rvalid      <= 1'b0;
            r_refill_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (evict_start) begin
                        r_state <= S_EVICT;
                        r_index <= evict_index;
                        r_beat  <= '0;
                    end else if (refill_start) begin
                        r_state <= S_REFILL;
                        r_index <= refill_index;
                        r_beat  <= '0;
                    end else if (cpu_rd) begin
                        r_rdata  <= w_cpu_word;
                        r_rvalid <= 1'b1;
                    end
                end
                S_REFILL: begin
                    if (refill_valid) begin
                        // Counter wraps naturally to 0 after the last beat.
                        r_beat <= r_beat + OFFSET_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state       <= S_IDLE;
                            r_refill_done <= 1'b1;
                        end
                    end
                end
                S_EVICT: begin
                    if (evict_ready) begin
                        r_beat <= r_beat + OFFSET_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_rdata    = r_rdata;
    assign cpu_rvalid   = r_rvalid;
    assign refill_done  = r_refill_done;
    assign busy         = (r_state != S_IDLE);
    assign refill_ready = (r_state == S_REFILL);
    assign evict_valid  = (r_state == S_EVICT);
    // Eviction data is a direct view of the latched word, so it stays put
    // for as long as the beat counter does (i.e. while stalled).
    assign evict_data   = evict_valid ? r_mem[r_index][r_beat] : '0;
    assign evict_last   = evict_valid && (r_beat == LAST_BEAT);

endmodule

// File: tb/tb_cache_line_store.sv
// Testbench for cache_line_store: default-parameter instance (A) driven from a
// table of CPU ops plus hand-written refill/evict/reset sequences, and a
// 64-bit / 8-word / 64-line instance (B) for the non-default geometry.
module tb_cache_line_store;

    localparam int IW  = 5;
    localparam int OW  = 2;
    localparam int BIW = 6;
    localparam int BOW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A signals
    logic          a_cpu_rd, a_cpu_wr;
    logic [IW-1:0] a_cpu_index;
    logic [OW-1:0] a_cpu_offset;
    logic [3:0]    a_cpu_be;
    logic [31:0]   a_cpu_wdata, a_cpu_rdata;
    logic          a_cpu_rvalid, a_busy;
    logic          a_refill_start, a_refill_valid, a_refill_ready, a_refill_done;
    logic [IW-1:0] a_refill_index, a_evict_index;
    logic [31:0]   a_refill_data, a_evict_data;
    logic          a_evict_start, a_evict_valid, a_evict_last, a_evict_ready;

    // Instance B signals
    logic           b_cpu_rd, b_cpu_wr;
    logic [BIW-1:0] b_cpu_index;
    logic [BOW-1:0] b_cpu_offset;
    logic [7:0]     b_cpu_be;
    logic [63:0]    b_cpu_wdata, b_cpu_rdata;
    logic           b_cpu_rvalid, b_busy;
    logic           b_refill_start, b_refill_valid, b_refill_ready, b_refill_done;
    logic [BIW-1:0] b_refill_index, b_evict_index;
    logic [63:0]    b_refill_data, b_evict_data;
    logic           b_evict_start, b_evict_valid, b_evict_last, b_evict_ready;

    cache_line_store u_a (
        .clk(clk), .reset(reset),
        .cpu_rd(a_cpu_rd), .cpu_wr(a_cpu_wr), .cpu_index(a_cpu_index),
        .cpu_offset(a_cpu_offset), .cpu_be(a_cpu_be), .cpu_wdata(a_cpu_wdata),
        .cpu_rdata(a_cpu_rdata), .cpu_rvalid(a_cpu_rvalid), .busy(a_busy),
        .refill_start(a_refill_start), .refill_index(a_refill_index),
        .refill_valid(a_refill_valid), .refill_data(a_refill_data),
        .refill_ready(a_refill_ready), .refill_done(a_refill_done),
        .evict_start(a_evict_start), .evict_index(a_evict_index),
        .evict_valid(a_evict_valid), .evict_data(a_evict_data),
        .evict_last(a_evict_last), .evict_ready(a_evict_ready)
    );

    cache_line_store #(.DATA_W(64), .WORDS_PER_LINE(8), .NUM_LINES(64)) u_b (
        .clk(clk), .reset(reset),
        .cpu_rd(b_cpu_rd), .cpu_wr(b_cpu_wr), .cpu_index(b_cpu_index),
        .cpu_offset(b_cpu_offset), .cpu_be(b_cpu_be), .cpu_wdata(b_cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid), .busy(b_busy),
        .refill_start(b_refill_start), .refill_index(b_refill_index),
        .refill_valid(b_refill_valid), .refill_data(b_refill_data),
        .refill_ready(b_refill_ready), .refill_done(b_refill_done),
        .evict_start(b_evict_start), .evict_index(b_evict_index),
        .evict_valid(b_evict_valid), .evict_data(b_evict_data),
        .evict_last(b_evict_last), .evict_ready(b_evict_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int a_done_cnt = 0;

    // Scoreboards: expected CPU read data and expected {last, data} beats.
    logic [31:0] aq_rd[$];
    logic [32:0] aq_ev[$];
    logic [64:0] bq_ev[$];

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bbeat(input int k);
        return 64'hA5A5_0000_0000_0000 | (64'(k) << 16) | 64'(k + 1);
    endfunction

    // Output monitor, sampled on the falling edge.
    logic [31:0] a_e_rd;
    logic [32:0] a_e_ev;
    logic [64:0] b_e_ev;
    logic        a_pv = 1'b0, a_pr = 1'b0, a_pl = 1'b0;
    logic [31:0] a_pd = '0;
    always @(negedge clk) begin
        if (a_cpu_rvalid) begin
            if (aq_rd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL cpu_rvalid_unexpected: got rdata %h, required no read", a_cpu_rdata);
            end else begin
                a_e_rd = aq_rd.pop_front();
                chk("cpu_rdata", 65'(a_cpu_rdata), 65'(a_e_rd));
            end
        end
        if (a_evict_valid && a_evict_ready) begin
            if (aq_ev.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL evict_beat_unexpected: got %h, required no beat", a_evict_data);
            end else begin
                a_e_ev = aq_ev.pop_front();
                chk("evict_beat", 65'({a_evict_last, a_evict_data}), 65'(a_e_ev));
            end
        end
        if (a_pv && !a_pr && a_evict_valid)
            chk("evict_hold", 65'({a_evict_last, a_evict_data}), 65'({a_pl, a_pd}));
        a_pv = a_evict_valid; a_pr = a_evict_ready;
        a_pl = a_evict_last;  a_pd = a_evict_data;
        if (a_refill_done) a_done_cnt++;
        if (b_evict_valid && b_evict_ready) begin
            if (bq_ev.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_evict_beat_unexpected: got %h, required no beat", b_evict_data);
            end else begin
                b_e_ev = bq_ev.pop_front();
                chk("b_evict_beat", {b_evict_last, b_evict_data}, b_e_ev);
            end
        end
    end

    typedef struct {
        logic          rd;
        logic          wr;
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic [3:0]    be;
        logic [31:0]   wdata;
        logic [31:0]   exp;
    } op_t;

    op_t ops[13];

    task automatic check_a_zero(input string tag);
        chk({tag, "_rdata"}, 65'(a_cpu_rdata), 65'd0);
        chk({tag, "_rvalid"}, 65'(a_cpu_rvalid), 65'd0);
        chk({tag, "_busy"}, 65'(a_busy), 65'd0);
        chk({tag, "_refill_ready"}, 65'(a_refill_ready), 65'd0);
        chk({tag, "_refill_done"}, 65'(a_refill_done), 65'd0);
        chk({tag, "_evict"}, 65'({a_evict_valid, a_evict_last, a_evict_data}), 65'd0);
    endtask

    initial begin
        //               rd    wr    idx    off   be       wdata          expected read
        ops[0]  = '{1'b1, 1'b0, 5'd5,  2'd2, 4'h0, 32'h0,         32'h0};
        ops[1]  = '{1'b0, 1'b1, 5'd3,  2'd1, 4'hF, 32'hAABBCCDD,  32'h0};
        ops[2]  = '{1'b0, 1'b1, 5'd3,  2'd1, 4'h5, 32'h11223344,  32'h0};
        ops[3]  = '{1'b1, 1'b0, 5'd3,  2'd1, 4'h0, 32'h0,         32'hAA22CC44};
        ops[4]  = '{1'b0, 1'b1, 5'd3,  2'd1, 4'h0, 32'hFFFFFFFF,  32'h0};
        ops[5]  = '{1'b1, 1'b0, 5'd3,  2'd1, 4'h0, 32'h0,         32'hAA22CC44};
        ops[6]  = '{1'b1, 1'b1, 5'd3,  2'd1, 4'hF, 32'h55667788,  32'hAA22CC44};
        ops[7]  = '{1'b1, 1'b0, 5'd3,  2'd1, 4'h0, 32'h0,         32'h55667788};
        ops[8]  = '{1'b0, 1'b1, 5'd31, 2'd3, 4'h8, 32'hDEADBEEF,  32'h0};
        ops[9]  = '{1'b1, 1'b0, 5'd31, 2'd3, 4'h0, 32'h0,         32'hDE000000};
        ops[10] = '{1'b1, 1'b0, 5'd3,  2'd0, 4'h0, 32'h0,         32'h0};
        ops[11] = '{1'b0, 1'b1, 5'd0,  2'd0, 4'h2, 32'h1234AB78,  32'h0};
        ops[12] = '{1'b1, 1'b0, 5'd0,  2'd0, 4'h0, 32'h0,         32'h0000AB00};

        reset = 1'b1;
        a_cpu_rd = 0; a_cpu_wr = 0; a_cpu_index = '0; a_cpu_offset = '0;
        a_cpu_be = '0; a_cpu_wdata = '0; a_refill_start = 0; a_refill_index = '0;
        a_refill_valid = 0; a_refill_data = '0; a_evict_start = 0;
        a_evict_index = '0; a_evict_ready = 0;
        b_cpu_rd = 0; b_cpu_wr = 0; b_cpu_index = '0; b_cpu_offset = '0;
        b_cpu_be = '0; b_cpu_wdata = '0; b_refill_start = 0; b_refill_index = '0;
        b_refill_valid = 0; b_refill_data = '0; b_evict_start = 0;
        b_evict_index = '0; b_evict_ready = 0;
        repeat (3) cyc();
        check_a_zero("reset");
        reset = 1'b0;
        cyc();

        // CPU read/write table
        foreach (ops[i]) begin
            a_cpu_rd = ops[i].rd;  a_cpu_wr = ops[i].wr;
            a_cpu_index = ops[i].idx; a_cpu_offset = ops[i].off;
            a_cpu_be = ops[i].be;  a_cpu_wdata = ops[i].wdata;
            if (ops[i].rd) aq_rd.push_back(ops[i].exp);
            cyc();
        end
        a_cpu_rd = 0; a_cpu_wr = 0;
        cyc();
        chk("rdata_hold", 65'(a_cpu_rdata), 65'h0000AB00);
        chk("rvalid_pulse_end", 65'(a_cpu_rvalid), 65'd0);

        // Refill line 7 with a 2-cycle gap; CPU ops while busy are ignored
        a_refill_start = 1; a_refill_index = 5'd7;
        cyc();
        a_refill_start = 0;
        chk("refill_busy", 65'({a_busy, a_refill_ready}), 65'b11);
        a_refill_valid = 1; a_refill_data = 32'h10; cyc();
        a_refill_data = 32'h20; cyc();
        a_refill_valid = 0;
        a_cpu_wr = 1; a_cpu_rd = 1; a_cpu_index = 5'd7; a_cpu_offset = 2'd0;
        a_cpu_be = 4'hF; a_cpu_wdata = 32'hFFFFFFFF;
        cyc();
        a_cpu_wr = 0; a_cpu_rd = 0;
        cyc();
        chk("refill_done_early", 65'(a_refill_done), 65'd0);
        a_refill_valid = 1; a_refill_data = 32'h30; cyc();
        a_refill_data = 32'h40; cyc();
        a_refill_valid = 0;
        chk("refill_done", 65'({a_refill_done, a_busy}), 65'b10);
        cyc();
        chk("refill_done_pulse", 65'(a_refill_done), 65'd0);
        for (int k = 0; k < 4; k++) begin
            a_cpu_rd = 1; a_cpu_index = 5'd7; a_cpu_offset = OW'(k);
            aq_rd.push_back(32'(16 * (k + 1)));
            cyc();
        end
        a_cpu_rd = 0;
        cyc();

        // Evict line 7 with back-pressure 1,0,0,1,1,1
        a_evict_start = 1; a_evict_index = 5'd7; a_evict_ready = 0;
        cyc();
        a_evict_start = 0;
        for (int k = 0; k < 4; k++) aq_ev.push_back({(k == 3), 32'(16 * (k + 1))});
        for (int i = 0; i < 6; i++) begin
            a_evict_ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            cyc();
        end
        a_evict_ready = 0;
        chk("evict_end", 65'({a_evict_valid, a_busy}), 65'd0);

        // Simultaneous starts: evict wins; then reset at beat 2
        a_evict_start = 1; a_evict_index = 5'd7;
        a_refill_start = 1; a_refill_index = 5'd2;
        cyc();
        a_evict_start = 0; a_refill_start = 0;
        chk("start_priority", 65'({a_evict_valid, a_refill_ready}), 65'b10);
        aq_ev.push_back({1'b0, 32'h10});
        aq_ev.push_back({1'b0, 32'h20});
        a_evict_ready = 1;
        cyc(); cyc();
        a_evict_ready = 0;
        chk("evict_beat2_data", 65'(a_evict_data), 65'h30);
        #1 reset = 1'b1;
        #1 check_a_zero("midevict_reset");
        cyc();
        reset = 1'b0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            a_cpu_rd = 1; a_cpu_index = 5'd7; a_cpu_offset = OW'(k);
            aq_rd.push_back(32'h0);
            cyc();
        end
        a_cpu_rd = 1; a_cpu_index = 5'd3; a_cpu_offset = 2'd1;
        aq_rd.push_back(32'h0);
        cyc();
        a_cpu_rd = 0;

        // Reset mid-refill: transfer abandoned, no refill_done
        a_refill_start = 1; a_refill_index = 5'd9;
        cyc();
        a_refill_start = 0; a_refill_valid = 1; a_refill_data = 32'h99;
        cyc();
        a_refill_valid = 0;
        reset = 1'b1;
        #1 chk("midrefill_reset", 65'({a_busy, a_refill_ready, a_refill_done}), 65'd0);
        cyc();
        reset = 1'b0;
        cyc(); cyc();
        chk("refill_done_count", 65'(a_done_cnt), 65'd1);

        // Instance B: 64-bit, 8 words/line, line 63
        b_refill_start = 1; b_refill_index = 6'd63;
        cyc();
        b_refill_start = 0;
        for (int k = 0; k < 8; k++) begin
            b_refill_valid = 1; b_refill_data = bbeat(k);
            cyc();
        end
        b_refill_valid = 0;
        chk("b_refill_done", 65'({b_refill_done, b_busy}), 65'b10);
        for (int rep = 0; rep < 2; rep++) begin
            b_evict_start = 1; b_evict_index = 6'd63; b_evict_ready = 1;
            for (int k = 0; k < 8; k++) bq_ev.push_back({(k == 7), bbeat(k)});
            cyc();
            b_evict_start = 0;
            chk("b_evict_first", {b_evict_last, b_evict_data}, {1'b0, bbeat(0)});
            repeat (8) cyc();
            chk("b_evict_end", 65'({b_evict_valid, b_busy}), 65'd0);
        end
        b_evict_ready = 0;
        b_cpu_rd = 1; b_cpu_index = 6'd63; b_cpu_offset = 3'd7;
        cyc();
        b_cpu_rd = 0;
        chk("b_read", {b_cpu_rvalid, b_cpu_rdata}, {1'b1, bbeat(7)});

        cyc(); cyc();
        chk("a_rd_queue_empty", 65'(aq_rd.size()), 65'd0);
        chk("a_ev_queue_empty", 65'(aq_ev.size()), 65'd0);
        chk("b_ev_queue_empty", 65'(bq_ev.size()), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
